ifetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle-style MIPS core. Holds the PC and issues word reads to instruction memory over a req/ack handshake. Presents each fetched word with its PC+4 to the decode stage, then computes the next PC from the branch/jump controls returned when decode accepts the instruction. Also counts retired instructions and traps misaligned targets and memory timeouts.

---
 rtl/ifetch_unit.sv | 137 +++++++++++++
 tb/tb_ifetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a req/ack
// handshake, hands words to decode and resolves the next PC on accept.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic [31:0]       Instruction,
  output logic [31:0]       opcplus4,
  output logic [31:0]       pc,
  output logic              inst_valid,
  input  logic              inst_accept,
  input  logic              Branch,
  input  logic              nBranch,
  input  logic              Jmp,
  input  logic              Jal,
  input  logic              Jr,
  input  logic              Zero,
  input  logic [31:0]       read_data_1,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [31:0]       retired_cnt
);

  typedef enum logic [1:0] {FETCH, WAIT, VALID, FAULT} state_e;

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] opc_q;
  logic [31:0] retired_q;
  logic        valid_q;
  logic        fault_q;
  logic [1:0]  code_q;
  logic [7:0]  tmo_q;

  logic [31:0] next_pc_d;
  logic [31:0] br_off;
  logic        br_taken;

  always_comb begin
    br_taken = (Branch & Zero) | (nBranch & ~Zero);
    br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    if (Jr)
      next_pc_d = read_data_1;
    else if (Jmp || Jal)
      next_pc_d = {opc_q[31:28], instr_q[25:0], 2'b00};
    else if (br_taken)
      next_pc_d = opc_q + br_off;
    else
      next_pc_d = opc_q;
  end

  // Request is gated by reset so an in-flight read is dropped the moment reset asserts.
  assign imem_req    = reset && ((state_q == FETCH) || (state_q == WAIT));
  assign imem_addr   = pc_q[ADDR_W+1:2];
  assign Instruction = instr_q;
  assign opcplus4    = opc_q;
  assign pc          = pc_q;
  assign inst_valid  = valid_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign retired_cnt = retired_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      opc_q     <= '0;
      retired_q <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      code_q    <= 2'd0;
      tmo_q     <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          tmo_q <= '0;
          if (imem_ack) begin
            instr_q <= imem_rdata;
            opc_q   <= pc_q + 32'd4;
            valid_q <= 1'b1;
            state_q <= VALID;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            opc_q   <= pc_q + 32'd4;
            valid_q <= 1'b1;
            state_q <= VALID;
          end else if (tmo_q + 8'd1 == TMO_LIM) begin
            fault_q <= 1'b1;
            code_q  <= 2'd2;
            state_q <= FAULT;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        VALID: begin
          if (inst_accept) begin
            // The faulting instruction still counts as retired.
            retired_q <= retired_q + 32'd1;
            valid_q   <= 1'b0;
            if (next_pc_d[1:0] != 2'b00) begin
              fault_q <= 1'b1;
              code_q  <= 2'd1;
              state_q <= FAULT;
            end else begin
              pc_q    <= next_pc_d;
              tmo_q   <= '0;
              state_q <= FETCH;
            end
          end
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: begin
          state_q <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: driver issues fetches/accepts from a PC model,
// a separate monitor checks each word presented to decode.
module tb_ifetch_unit;
  localparam int unsigned ADDR_W = 14;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata = '0;
  logic              imem_ack = 1'b0;
  logic [31:0]       Instruction;
  logic [31:0]       opcplus4;
  logic [31:0]       pc;
  logic              inst_valid;
  logic              inst_accept = 1'b0;
  logic              Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jr = 1'b0, Zero = 1'b0;
  logic [31:0]       read_data_1 = '0;
  logic              fault;
  logic [1:0]        fault_code;
  logic [31:0]       retired_cnt;

  ifetch_unit #(.RESET_PC(RST_PC), .ADDR_W(ADDR_W), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .Instruction(Instruction),
    .opcplus4(opcplus4), .pc(pc), .inst_valid(inst_valid), .inst_accept(inst_accept),
    .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr), .Zero(Zero),
    .read_data_1(read_data_1), .fault(fault), .fault_code(fault_code),
    .retired_cnt(retired_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] opc;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_retired = '0;

  // control vector bit positions: {jr, jmp, jal, br, nbr, zero}
  localparam logic [5:0] C_JR = 6'b100000, C_JMP = 6'b010000, C_JAL = 6'b001000;
  localparam logic [5:0] C_BR = 6'b000100, C_NBR = 6'b000010, C_Z = 6'b000001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] w, input logic [31:0] opc,
                                           input logic [31:0] rd1, input logic [5:0] c);
    logic signed [31:0] imm;
    imm = $signed(w[15:0]);
    if (c[5]) return rd1;
    if (c[4] || c[3]) return {opc[31:28], w[25:0], 2'b00};
    if ((c[2] && c[0]) || (c[1] && !c[0])) return opc + 32'(imm * 4);
    return opc;
  endfunction

  // Monitor: every rising inst_valid must match the oldest outstanding fetch.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (reset && inst_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid with empty scoreboard, expected none");
        end else begin
          e = exp_q.pop_front();
          chk("instruction", Instruction, e.instr);
          chk("opcplus4", opcplus4, e.opc);
          chk("held_pc", pc, e.pc);
        end
      end
      prev_valid = reset && inst_valid;
    end
  end

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", Instruction, 32'd0);
    chk("rst_opcplus4", opcplus4, 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_fault", {29'd0, fault, fault_code}, 32'd0);
    chk("rst_retired", retired_cnt, 32'd0);
    exp_q.delete();
    m_pc = RST_PC;
    m_retired = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clock);
      n++;
    end
    ok = imem_req;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: imem_req low for %0d cycles, expected 1", n);
    end
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!inst_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    ok = inst_valid;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: inst_valid low for %0d cycles, expected 1", n);
    end
  endtask

  task automatic do_fetch(input logic [31:0] word, input int lat, output bit ok);
    wait_req(ok);
    if (!ok) return;
    chk("imem_addr", 32'(imem_addr), 32'(m_pc[ADDR_W+1:2]));
    exp_q.push_back('{instr: word, opc: m_pc + 32'd4, pc: m_pc});
    for (int i = 0; i < lat; i++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      @(negedge clock);
      chk("wait_addr_stable", {imem_req, 17'd0, imem_addr}, {1'b1, 17'd0, m_pc[ADDR_W+1:2]});
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    @(negedge clock);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic step(input logic [31:0] word, input int lat, input logic [5:0] c,
                      input logic [31:0] rd1);
    bit ok;
    logic [31:0] nxt;
    do_fetch(word, lat, ok);
    if (!ok) return;
    wait_valid(ok);
    if (!ok) return;
    repeat ($urandom_range(0, 2)) @(negedge clock);
    nxt = ref_next(word, m_pc + 32'd4, rd1, c);
    {Jr, Jmp, Jal, Branch, nBranch, Zero} = c;
    read_data_1 = rd1;
    inst_accept = 1'b1;
    @(negedge clock);
    inst_accept = 1'b0;
    {Jr, Jmp, Jal, Branch, nBranch, Zero} = 6'b0;
    read_data_1 = $urandom;
    m_retired = m_retired + 32'd1;
    chk("retired_cnt", retired_cnt, m_retired);
    if (nxt[1:0] != 2'b00) begin
      chk("misalign_fault", {29'd0, fault, fault_code}, {29'd0, 1'b1, 2'd1});
      chk("misalign_pc_held", pc, m_pc);
    end else begin
      m_pc = nxt;
      chk("next_pc", pc, m_pc);
      chk("no_fault", 32'(fault), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [31:0] w;
    logic [5:0]  c;
    do_reset();

    // Sequential fetch, zero-wait memory
    for (int i = 0; i < 4; i++) step($urandom, 0, 6'b0, 32'd0);
    chk("seq_retired", retired_cnt, 32'd4);
    chk("seq_pc", pc, 32'h10);

    // Branches from pc=0x40 with imm=-2
    w = {6'b000100, 5'd1, 5'd2, 16'hFFFE};
    step($urandom, 0, C_JR, 32'h40);
    step(w, 0, C_BR | C_Z, 32'd0);
    chk("beq_taken_pc", pc, 32'h3C);
    chk("beq_taken_addr", 32'(imem_addr), 32'h0F);
    step($urandom, 0, C_JR, 32'h40);
    step(w, 0, C_BR, 32'd0);
    chk("beq_not_taken_pc", pc, 32'h44);
    step($urandom, 1, C_JR, 32'h40);
    step(w, 0, C_NBR, 32'd0);
    chk("bne_taken_pc", pc, 32'h3C);

    // Jumps and Jr priority
    step($urandom, 0, C_JR, 32'h1000_0000);
    step({6'b000010, 26'h000010}, 0, C_JMP, 32'd0);
    chk("j_pc", pc, 32'h1000_0040);
    step($urandom, 0, C_JR, 32'h200);
    chk("jr_pc", pc, 32'h200);
    step($urandom, 2, C_JR | C_JMP, 32'h200);
    chk("jr_prio_pc", pc, 32'h200);

    // Wait states
    step(32'hDEAD_BEEF, 3, 6'b0, 32'd0);
    chk("wait3_pc", pc, 32'h204);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      c = {($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))};
      step($urandom, int'($urandom_range(0, 4)), c, $urandom & 32'hFFFF_FFFC);
    end

    // Misaligned Jr target
    step($urandom, 0, C_JR, 32'h0000_0202);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("fault_no_req", {30'd0, imem_req, inst_valid}, 32'd0);
    end
    chk("fault_sticky", {29'd0, fault, fault_code}, {29'd0, 1'b1, 2'd1});
    do_reset();

    // Timeout after 8 wait cycles
    wait_req(ok);
    imem_ack = 1'b0;
    repeat (8) @(negedge clock);
    chk("tmo_pending", {30'd0, imem_req, fault}, {30'd0, 1'b1, 1'b0});
    @(negedge clock);
    chk("tmo_fault", {29'd0, fault, fault_code}, {29'd0, 1'b1, 2'd2});
    chk("tmo_no_req", 32'(imem_req), 32'd0);
    do_reset();

    // Async reset mid-WAIT, then restart
    wait_req(ok);
    @(negedge clock);
    @(negedge clock);
    do_reset();
    step($urandom, 0, 6'b0, 32'd0);
    chk("restart_pc", pc, 32'h4);

    // Async reset mid-VALID, then restart
    do_fetch($urandom, 1, ok);
    wait_valid(ok);
    do_reset();
    step($urandom, 0, 6'b0, 32'd0);
    chk("restart2_retired", retired_cnt, 32'd1);

    repeat (2) @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
